hit_monit_scheduler: RTL and testbench

Sequencer for the hit/busy counting block. It generates the periodic `update_end` strobe and rotates or fixes the monitored hit and busy channel selections at each period boundary. It blanks monitoring during a settle window after each switch. It raises a snapshot request to readout and flags overruns when readout does not acknowledge in time.

---
 rtl/monit_sched_pkg.sv | 15 +
 rtl/monit_period_timer.sv | 31 +++
 rtl/hit_monit_scheduler.sv | 156 +++++++++++++++
 tb/tb_hit_monit_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/monit_sched_pkg.sv
// Shared types and widths for the hit/busy monitor scheduler.
package monit_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam int SEL_W  = 3;
    localparam int PCNT_W = 16;
    localparam int OCNT_W = 8;

endpackage

// File: rtl/monit_period_timer.sv
// Period timer: counts 0..PERIOD-1 while enabled and flags the two
// positions the scheduler FSM branches on.
module monit_period_timer #(
    parameter int PERIOD = 50_000,
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic settle_done,
    output logic period_last
);

    localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 2;

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == TW'(PERIOD - 1)) ? '0 : count_reg + TW'(1);
        end
    end

    // period_last fires one clock early so the FSM lands in UPDATE on PERIOD-1
    assign settle_done = (count_reg == TW'(SETTLE - 1));
    assign period_last = (count_reg == TW'(PERIOD - 2));

endmodule

// File: rtl/hit_monit_scheduler.sv
// Sequencer for hit/busy counting: periodic update strobe, channel rotation,
// settle blanking and snapshot request/overrun tracking.
module hit_monit_scheduler
    import monit_sched_pkg::*;
#(
    parameter int UPDATE_PERIOD = 50_000,
    parameter int SETTLE_CYCLES = 4,
    parameter int HIT_CH        = 8,
    parameter int BUSY_CH       = 2
) (
    input  logic              clk_in,
    input  logic              rst_in_N,
    input  logic              enable_in,
    input  logic              hit_fix_en_in,
    input  logic [SEL_W-1:0]  hit_monit_fix_sel_in,
    input  logic              busy_fix_en_in,
    input  logic              busy_monit_fix_sel_in,
    input  logic              snap_ack_in,
    output logic              update_end_out,
    output logic [SEL_W-1:0]  hit_monit_sel_out,
    output logic              busy_monit_sel_out,
    output logic              monit_valid_out,
    output logic              snap_req_out,
    output logic              overrun_out,
    output logic [OCNT_W-1:0] overrun_cnt_out,
    output logic [PCNT_W-1:0] period_cnt_out,
    output logic [1:0]        state_out
);

    state_t state_reg, state_next;

    logic settle_done;
    logic period_last;
    logic timer_clr;

    logic [SEL_W-1:0]  hit_sel_reg, hit_sel_next;
    logic              busy_sel_reg, busy_sel_next;
    logic [PCNT_W-1:0] period_cnt_reg;
    logic [OCNT_W-1:0] overrun_cnt_reg;
    logic              update_end_reg;
    logic              monit_valid_reg;
    logic              snap_req_reg;
    logic              overrun_reg;

    logic start_run;
    logic boundary;
    logic enter_update;

    assign timer_clr = (state_reg == ST_IDLE) || !enable_in;

    monit_period_timer #(
        .PERIOD (UPDATE_PERIOD),
        .SETTLE (SETTLE_CYCLES)
    ) u_timer (
        .clk         (clk_in),
        .rst_n       (rst_in_N),
        .clr         (timer_clr),
        .en          (enable_in),
        .settle_done (settle_done),
        .period_last (period_last)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable_in) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_next = ST_COUNT;
                ST_COUNT:  if (period_last) state_next = ST_UPDATE;
                ST_UPDATE: state_next = ST_SETTLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign start_run    = (state_reg == ST_IDLE)   && (state_next == ST_SETTLE);
    assign boundary     = (state_reg == ST_UPDATE) && (state_next == ST_SETTLE);
    assign enter_update = (state_reg != ST_UPDATE) && (state_next == ST_UPDATE);

    // Fix inputs are only looked at when a period starts, never mid-period
    always_comb begin
        hit_sel_next  = hit_sel_reg;
        busy_sel_next = busy_sel_reg;
        if (start_run) begin
            hit_sel_next  = hit_fix_en_in  ? hit_monit_fix_sel_in  : '0;
            busy_sel_next = busy_fix_en_in ? busy_monit_fix_sel_in : 1'b0;
        end else if (boundary) begin
            if (hit_fix_en_in) begin
                hit_sel_next = hit_monit_fix_sel_in;
            end else if (hit_sel_reg == SEL_W'(HIT_CH - 1)) begin
                hit_sel_next = '0;
            end else begin
                hit_sel_next = hit_sel_reg + SEL_W'(1);
            end
            if (busy_fix_en_in) begin
                busy_sel_next = busy_monit_fix_sel_in;
            end else if (busy_sel_reg == 1'(BUSY_CH - 1)) begin
                busy_sel_next = 1'b0;
            end else begin
                busy_sel_next = busy_sel_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_N) begin
            update_end_reg  <= 1'b0;
            monit_valid_reg <= 1'b0;
            hit_sel_reg     <= '0;
            busy_sel_reg    <= 1'b0;
            period_cnt_reg  <= '0;
            snap_req_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            overrun_cnt_reg <= '0;
        end else begin
            update_end_reg  <= (state_next == ST_UPDATE);
            monit_valid_reg <= (state_next == ST_COUNT);
            hit_sel_reg     <= hit_sel_next;
            busy_sel_reg    <= busy_sel_next;
            if (enter_update) begin
                period_cnt_reg <= period_cnt_reg + PCNT_W'(1);
                snap_req_reg   <= 1'b1;
                // A coincident ack retires the old request, so no overrun
                if (snap_req_reg && !snap_ack_in) begin
                    overrun_reg <= 1'b1;
                    if (overrun_cnt_reg != '1) begin
                        overrun_cnt_reg <= overrun_cnt_reg + OCNT_W'(1);
                    end
                end
            end else if (snap_req_reg && snap_ack_in) begin
                snap_req_reg <= 1'b0;
            end
        end
    end

    assign update_end_out     = update_end_reg;
    assign monit_valid_out    = monit_valid_reg;
    assign hit_monit_sel_out  = hit_sel_reg;
    assign busy_monit_sel_out = busy_sel_reg;
    assign period_cnt_out     = period_cnt_reg;
    assign snap_req_out       = snap_req_reg;
    assign overrun_out        = overrun_reg;
    assign overrun_cnt_out    = overrun_cnt_reg;
    assign state_out          = state_reg;

endmodule

// File: tb/tb_hit_monit_scheduler.sv
// Directed bench for hit_monit_scheduler with UPDATE_PERIOD=20, SETTLE_CYCLES=3.
module tb_hit_monit_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       hit_fix_en;
    logic [2:0] hit_fix_sel;
    logic       busy_fix_en;
    logic       busy_fix_sel;
    logic       snap_ack;
    logic       update_end;
    logic [2:0] hit_sel;
    logic       busy_sel;
    logic       valid;
    logic       snap_req;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic [15:0] period_cnt;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int exp_hit;
    int exp_busy;
    int exp_pcnt;
    int period_idx = 0;

    hit_monit_scheduler #(
        .UPDATE_PERIOD (20),
        .SETTLE_CYCLES (3),
        .HIT_CH        (8),
        .BUSY_CH       (2)
    ) dut (
        .clk_in                (clk),
        .rst_in_N              (rst_n),
        .enable_in             (enable),
        .hit_fix_en_in         (hit_fix_en),
        .hit_monit_fix_sel_in  (hit_fix_sel),
        .busy_fix_en_in        (busy_fix_en),
        .busy_monit_fix_sel_in (busy_fix_sel),
        .snap_ack_in           (snap_ack),
        .update_end_out        (update_end),
        .hit_monit_sel_out     (hit_sel),
        .busy_monit_sel_out    (busy_sel),
        .monit_valid_out       (valid),
        .snap_req_out          (snap_req),
        .overrun_out           (overrun),
        .overrun_cnt_out       (overrun_cnt),
        .period_cnt_out        (period_cnt),
        .state_out             (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full period starting from the first SETTLE clock.
    // ack_mode: 0 none, 1 ack two clocks in, 2 ack coincident with UPDATE entry.
    // fix_action: 0 none, 1 fix hit to 5 mid-period, 2 release hit fix mid-period.
    task automatic do_period(input int ack_mode, input int fix_action);
        int exp_state;
        for (int t = 1; t <= 20; t++) begin
            tick();
            exp_state = (t <= 3) ? 1 : ((t < 20) ? 2 : 3);
            total++;
            if (state !== 2'(exp_state)) begin
                bad++;
                $display("FAIL period_state p=%0d t=%0d got=%0d exp=%0d", period_idx, t, state, exp_state);
            end
            total++;
            if (update_end !== (t == 20)) begin
                bad++;
                $display("FAIL period_strobe p=%0d t=%0d got=%0b exp=%0b", period_idx, t, update_end, (t == 20));
            end
            total++;
            if (valid !== (t >= 4 && t <= 19)) begin
                bad++;
                $display("FAIL period_valid p=%0d t=%0d got=%0b exp=%0b", period_idx, t, valid, (t >= 4 && t <= 19));
            end
            total++;
            if (hit_sel !== 3'(exp_hit) || busy_sel !== 1'(exp_busy)) begin
                bad++;
                $display("FAIL period_sel p=%0d t=%0d got=%0d/%0d exp=%0d/%0d", period_idx, t, hit_sel, busy_sel, exp_hit, exp_busy);
            end
            if (ack_mode == 1 && t == 4) begin
                total++;
                if (snap_req !== 1'b0) begin
                    bad++;
                    $display("FAIL req_cleared p=%0d got=%0b exp=0", period_idx, snap_req);
                end
            end
            if (t == 20) begin
                exp_pcnt = (exp_pcnt + 1) % 65536;
                total++;
                if (period_cnt !== 16'(exp_pcnt)) begin
                    bad++;
                    $display("FAIL period_cnt p=%0d got=%0d exp=%0d", period_idx, period_cnt, exp_pcnt);
                end
                total++;
                if (snap_req !== 1'b1) begin
                    bad++;
                    $display("FAIL req_set p=%0d got=%0b exp=1", period_idx, snap_req);
                end
            end
            if (ack_mode == 1 && t == 2)  snap_ack = 1'b1;
            if (ack_mode == 1 && t == 3)  snap_ack = 1'b0;
            if (ack_mode == 2 && t == 19) snap_ack = 1'b1;
            if (ack_mode == 2 && t == 20) snap_ack = 1'b0;
            if (fix_action == 1 && t == 10) begin
                hit_fix_en  = 1'b1;
                hit_fix_sel = 3'd5;
            end
            if (fix_action == 2 && t == 10) hit_fix_en = 1'b0;
        end
        $display("period %0d: hit=%0d busy=%0d pcnt=%0d req=%0b ovr=%0b ocnt=%0d",
                 period_idx, hit_sel, busy_sel, period_cnt, snap_req, overrun, overrun_cnt);
        period_idx++;
        exp_hit  = hit_fix_en ? int'(hit_fix_sel) : (exp_hit + 1) % 8;
        exp_busy = (exp_busy + 1) % 2;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({state, update_end, valid, hit_sel, busy_sel, snap_req, overrun, overrun_cnt, period_cnt} !== '0) begin
            bad++;
            $display("FAIL %s got st=%0d ue=%0b v=%0b hit=%0d busy=%0d req=%0b ovr=%0b ocnt=%0d pcnt=%0d exp=all_zero",
                     name, state, update_end, valid, hit_sel, busy_sel, snap_req, overrun, overrun_cnt, period_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; hit_fix_en = 1'b0; hit_fix_sel = 3'd0;
        busy_fix_en = 1'b0; busy_fix_sel = 1'b0; snap_ack = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_rotation();
        exp_hit = 0; exp_busy = 0; exp_pcnt = 0;
        enable = 1'b1;
        for (int p = 0; p < 9; p++) do_period(1, 0);
        total++;
        if (period_cnt !== 16'd9 || hit_sel !== 3'd0) begin
            bad++;
            $display("FAIL rotation_end got pcnt=%0d hit=%0d exp pcnt=9 hit=0", period_cnt, hit_sel);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL rotation_no_overrun got=%0b exp=0", overrun);
        end
    endtask

    task automatic test_hit_fix();
        do_period(1, 1);
        do_period(1, 0);
        do_period(1, 2);
        do_period(1, 0);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL fix_no_overrun got=%0b exp=0", overrun);
        end
    endtask

    task automatic test_overrun();
        do_period(0, 0);
        total++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            bad++;
            $display("FAIL overrun_first got ovr=%0b cnt=%0d exp ovr=1 cnt=1", overrun, overrun_cnt);
        end
        do_period(0, 0);
        total++;
        if (overrun_cnt !== 8'd2) begin
            bad++;
            $display("FAIL overrun_second got=%0d exp=2", overrun_cnt);
        end
    endtask

    task automatic test_coincident_ack();
        do_period(2, 0);
        total++;
        if (overrun_cnt !== 8'd2 || snap_req !== 1'b1) begin
            bad++;
            $display("FAIL coincident_ack got cnt=%0d req=%0b exp cnt=2 req=1", overrun_cnt, snap_req);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        for (int i = 1; i <= 255; i++) begin
            do_period(0, 0);
            exp_cnt = (2 + i > 255) ? 255 : 2 + i;
            total++;
            if (overrun_cnt !== 8'(exp_cnt)) begin
                bad++;
                $display("FAIL overrun_sat i=%0d got=%0d exp=%0d", i, overrun_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_enable_drop();
        int held_pcnt;
        held_pcnt = exp_pcnt;
        for (int t = 1; t <= 11; t++) tick();
        enable = 1'b0;
        tick();
        total++;
        if (state !== 2'd0 || valid !== 1'b0 || update_end !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle got st=%0d v=%0b ue=%0b exp st=0 v=0 ue=0", state, valid, update_end);
        end
        total++;
        if (hit_sel !== 3'(exp_hit) || busy_sel !== 1'(exp_busy)) begin
            bad++;
            $display("FAIL drop_sel_hold got=%0d/%0d exp=%0d/%0d", hit_sel, busy_sel, exp_hit, exp_busy);
        end
        for (int t = 0; t < 25; t++) begin
            tick();
            if (update_end !== 1'b0 || state !== 2'd0) begin
                total++;
                bad++;
                $display("FAIL drop_no_strobe t=%0d got ue=%0b st=%0d exp ue=0 st=0", t, update_end, state);
            end
        end
        total++;
        if (snap_req !== 1'b1 || period_cnt !== 16'(held_pcnt)) begin
            bad++;
            $display("FAIL drop_req_hold got req=%0b pcnt=%0d exp req=1 pcnt=%0d", snap_req, period_cnt, held_pcnt);
        end
        exp_hit = 0; exp_busy = 0;
        enable = 1'b1;
        do_period(1, 0);
    endtask

    task automatic test_reset_in_update();
        do_period(0, 0);
        total++;
        if (state !== 2'd3 || snap_req !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_update got st=%0d req=%0b exp st=3 req=1", state, snap_req);
        end
        rst_n = 1'b0;
        tick();
        check_all_zero("reset_in_update");
        rst_n = 1'b1;
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hit_fix();
        test_overrun();
        test_coincident_ack();
        test_saturation();
        test_enable_drop();
        test_reset_in_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
